// File: rtl/output_uart_tx_if.sv
// Word interface between the CPU OUT register and the serial output stage.
// master: drives data_in/word_en and observes tx/busy/fifo_count/overflow.
// slave : the UART transmitter side.
interface output_uart_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      data_in;     // word from the CPU OUT register
    logic             word_en;     // write strobe, one word per high cycle
    logic             tx;          // UART line, idle high
    logic             busy;        // transmitting or words queued
    logic [CNT_W-1:0] fifo_count;  // words currently queued
    logic             overflow;    // sticky, a write was dropped

    modport master (
        output data_in, word_en,
        input  tx, busy, fifo_count, overflow
    );

    modport slave (
        input  data_in, word_en,
        output tx, busy, fifo_count, overflow
    );
endinterface

// File: rtl/output_uart_tx.sv
// Purpose: buffer 32-bit CPU output words and send each as four 8N1 frames, MSB byte first.
// Latency: tx falls one edge after a write into an empty, idle block; a word takes 40*CLKS_PER_BIT cycles.
// Backpressure: none; a write to a full FIFO (no pop on that edge) is dropped and sets sticky overflow.
//
// Ports: clk (rising edge), clr (async active-high reset), bus (output_uart_tx_if.slave:
//        data_in, word_en in; tx, busy, fifo_count, overflow out).
// Optional feature: define OUTPUT_UART_TX_CHANGE_DETECT_EN to also write whenever data_in
//        differs from its value on the previous edge (for hookup without a strobe).
module output_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            clr,
    output_uart_tx_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------------------------------------------------------
    // Write strobe
    // ---------------------------------------------------------------
    logic wr;

`ifdef OUTPUT_UART_TX_CHANGE_DETECT_EN
    logic [31:0] last_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            last_q <= '0;
        end else begin
            last_q <= bus.data_in;
        end
    end

    assign wr = bus.word_en | (bus.data_in != last_q);
`else
    assign wr = bus.word_en;
`endif

    // ---------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             pop;
    logic             accept;
    logic             fifo_empty;

    assign fifo_empty = (count_q == '0);
    // A pop on the same edge frees a slot, so a full FIFO still takes the write.
    assign accept     = wr && ((count_q != CNT_FULL) || pop);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (wr && !accept) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Transmit FSM
    // ---------------------------------------------------------------
    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             tick;
    logic [7:0]       byte_cur;

    assign tick     = (timer_q == TMR_LAST);
    // The byte on the wire is always the top of the shift register.
    assign byte_cur = shreg_q[31:24];

    // State and datapath registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty)             state_d = S_START;
            S_START: if (tick)                    state_d = S_DATA;
            S_DATA:  if (tick && bit_q == 3'd7)   state_d = S_STOP;
            S_STOP:  if (tick)                    state_d = (byte_q != 2'd3) ? S_START : S_IDLE;
            default:                              state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; tx_d is registered so the line never glitches.
    always_comb begin
        pop     = 1'b0;
        tx_d    = tx_q;
        timer_d = tick ? '0 : timer_q + TMR_W'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                tx_d    = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr_q];
                    byte_d  = 2'd0;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    bit_d = 3'd0;
                    tx_d  = byte_cur[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = byte_cur[bit_q + 3'd1];
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        shreg_d = {shreg_q[23:0], 8'h00};
                        tx_d    = 1'b0;
                    end else begin
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = (state_q != S_IDLE) || !fifo_empty;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_output_uart_tx.sv
`timescale 1ns/1ps
module tb_output_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    output_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    output_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected bytes in send order; decoded frames from the line.
    logic [7:0] exp_q [$];
    logic [9:0] rx_q  [$];   // {stop, data[7:0], start}
    int         rx_rd = 0;

    // Line decoder: sample mid-bit on the falling clock edge.
    logic       mact;
    int         mcnt;
    logic [9:0] mframe;
    always @(negedge clk or posedge clr) begin
        if (clr) begin
            mact <= 1'b0;
            mcnt <= 0;
        end else if (!mact) begin
            if (bus.tx === 1'b0) begin
                mact <= 1'b1;
                mcnt <= 1;
            end
        end else begin
            if (mcnt % CPB == CPB / 2) mframe[mcnt / CPB] <= bus.tx;
            if (mcnt == 9 * CPB + CPB / 2) begin
                rx_q.push_back({bus.tx, mframe[8:0]});
                mact <= 1'b0;
            end
            mcnt <= mcnt + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic write_word(input logic [31:0] w, input bit expect_sent);
        bus.data_in = w;
        bus.word_en = 1'b1;
        if (expect_sent) push_word(w);
        step();
        bus.word_en = 1'b0;
    endtask

    task automatic drain(input string tag, input int nbytes, input int budget);
        int n = 0;
        logic [9:0] f;
        logic [7:0] e;
        while ((rx_q.size() - rx_rd) < nbytes && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_bytes_arrived"}, 32'((rx_q.size() - rx_rd) >= nbytes), 32'd1);
        for (int i = 0; i < nbytes; i++) begin
            if (rx_rd < rx_q.size() && exp_q.size() > 0) begin
                f = rx_q[rx_rd];
                rx_rd++;
                e = exp_q.pop_front();
                chk({tag, "_byte"}, 32'(f[8:1]), 32'(e));
                chk({tag, "_framing"}, 32'({f[9], f[0]}), 32'b10);
            end
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        bus.data_in = 32'h0;
        bus.word_en = 1'b0;
        step();
        clr = 1'b0;
        step();
        exp_q.delete();
        rx_rd = rx_q.size();
    endtask

    initial begin
        int n;
        bit line_ok;
        int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};

        clr         = 1'b1;
        bus.data_in = 32'h0;
        bus.word_en = 1'b0;
        steps(2);
        chk("reset_tx", 32'(bus.tx), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_count", 32'(bus.fifo_count), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        clr = 1'b0;
        step();

        // Single word: latency, frame content, total length, busy fall.
        write_word(32'h12345678, 1'b1);
        chk("w1_count_after_write", 32'(bus.fifo_count), 32'd1);
        chk("w1_busy_after_write", 32'(bus.busy), 32'd1);
        chk("w1_tx_after_write", 32'(bus.tx), 32'd1);
        step();
        chk("w1_tx_fall", 32'(bus.tx), 32'd0);
        chk("w1_count_after_pop", 32'(bus.fifo_count), 32'd0);
        n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk("w1_word_cycles", 32'(n), 32'd160);
        chk("w1_tx_idle", 32'(bus.tx), 32'd1);
        drain("w1", 4, 50);

        // Six back-to-back writes into a depth-4 FIFO.
        for (int i = 1; i <= 6; i++) begin
            bus.data_in = 32'(i);
            bus.word_en = 1'b1;
            if (i <= 5) push_word(32'(i));
            step();
            chk($sformatf("burst_count_%0d", i), 32'(bus.fifo_count), 32'(exp_cnt[i-1]));
            chk($sformatf("burst_overflow_%0d", i), 32'(bus.overflow), 32'(i == 6));
        end
        bus.word_en = 1'b0;
        drain("burst", 20, 5 * 165 + 50);
        chk("burst_overflow_sticky", 32'(bus.overflow), 32'd1);

        pulse_clr();
        chk("clr_overflow", 32'(bus.overflow), 32'd0);

        // Full FIFO with a write landing on the pop edge.
        write_word(32'hA0A1A2A3, 1'b1);
        step();
        chk("full_tx_fall", 32'(bus.tx), 32'd0);
        write_word(32'h01020304, 1'b1);
        write_word(32'h05060708, 1'b1);
        write_word(32'h090A0B0C, 1'b1);
        write_word(32'h0D0E0F10, 1'b1);
        steps(156);
        chk("full_count_before_pop", 32'(bus.fifo_count), 32'd4);
        chk("full_tx_before_pop", 32'(bus.tx), 32'd1);
        bus.data_in = 32'h000000AA;
        bus.word_en = 1'b1;
        push_word(32'h000000AA);
        step();
        bus.word_en = 1'b0;
        chk("full_count_after_pop_write", 32'(bus.fifo_count), 32'd4);
        chk("full_overflow_after_pop_write", 32'(bus.overflow), 32'd0);
        chk("full_next_word_started", 32'(bus.tx), 32'd0);
        drain("full", 24, 6 * 165);

        // Reset in the middle of the third byte's data bits.
        write_word(32'h11223344, 1'b0);
        step();
        write_word(32'h55667788, 1'b0);
        steps(99);
        clr = 1'b1;
        bus.data_in = 32'h0;
        #1;
        chk("midclr_tx", 32'(bus.tx), 32'd1);
        chk("midclr_count", 32'(bus.fifo_count), 32'd0);
        chk("midclr_busy", 32'(bus.busy), 32'd0);
        steps(2);
        clr = 1'b0;
        exp_q.delete();
        rx_rd = rx_q.size();
        line_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) line_ok = 1'b0;
        end
        chk("postclr_line_idle", 32'(line_ok), 32'd1);
        chk("postclr_no_frames", 32'(rx_q.size() - rx_rd), 32'd0);
        write_word(32'hDEADBEEF, 1'b1);
        drain("postclr", 4, 200);

        // Value change without a strobe.
        pulse_clr();
        bus.data_in = 32'h000000A5;
`ifdef OUTPUT_UART_TX_CHANGE_DETECT_EN
        push_word(32'h000000A5);
        step();
        chk("cd_count_after_change", 32'(bus.fifo_count), 32'd1);
        drain("cd", 4, 300);
        steps(5);
`endif
        line_ok = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step();
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) line_ok = 1'b0;
        end
        chk("cd_hold_line_idle", 32'(line_ok), 32'd1);
        chk("cd_hold_no_frames", 32'(rx_q.size() - rx_rd), 32'd0);
        chk("cd_hold_count", 32'(bus.fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/output_uart_tx.md
# output_uart_tx

Serial output stage placed directly downstream of the CPU's OUT register on the DE0 top level. Accepts 32-bit words from the CPU output port, buffers them in a small FIFO and transmits each word as four 8N1 UART frames, most significant byte first. Program output can be viewed on a host terminal without the seven-segment display. Contains no CPU-specific logic beyond the 32-bit word interface.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2
- FIFO_DEPTH, 4, buffered words; power of two, ≥ 2
- clk  input  1  system clock, rising edge
- clr  input  1  reset, asynchronous, active-high
- data_in  input  32  word from the CPU OUT register
- word_en  input  1  write strobe; data_in is sampled on a rising edge where word_en=1
- tx  output  1  UART line, idle high
- busy  output  1  FSM not in IDLE, or FIFO non-empty
- fifo_count  output  $clog2(FIFO_DEPTH+1)  words currently queued
- overflow  output  1  sticky; set when a write is dropped; cleared only by clr

## Operation
- FIFO: circular buffer with read/write pointers and a count.
  - Write accepted if count < FIFO_DEPTH, or if a pop occurs on the same edge.
  - A write that is not accepted is dropped and sets overflow.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head word into a 32-bit shift register, set byte index to 0, go to START with tx=0.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive the current byte LSB-first, one bit per CLKS_PER_BIT cycles. After bit 7, go to STOP with tx=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles, then:
    - if byte index < 3: increment byte index, shift the word left 8, go to START;
    - else: go to IDLE. If the FIFO is non-empty, the next word starts on the following edge.
- Byte order: data_in[31:24] first, [7:0] last.
- Frame timing:
  - frame = 10 bits; word = 40 bits = 40·CLKS_PER_BIT cycles from start-bit fall to end of last stop bit;
  - one IDLE cycle between consecutive words.
- tx is a register output, so it is glitch-free.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. Width is $clog2(CLKS_PER_BIT).

## Timing
- Reset values (asynchronous, take effect immediately):
  - tx=1, busy=0, fifo_count=0, overflow=0;
  - FSM=IDLE, pointers=0, timers=0.
- Reset mid-frame: tx returns high at once, queued words are discarded, and no partial frame resumes after reset.
- Write latency with the FIFO empty and the FSM in IDLE:
  - after write edge k: fifo_count=1;
  - after edge k+1: pop, fifo_count=0, tx=0.
- busy:
  - rises after the write edge;
  - falls after the edge that ends the final stop bit, if the FIFO is empty.
- Write while full, with no pop on the same edge: data dropped, overflow=1 from the next cycle, fifo_count unchanged.
- Write and pop on the same edge with the FIFO full: write accepted, fifo_count unchanged, overflow unchanged.
- word_en held high for N cycles means N writes. No edge detection is applied to word_en.

## Configuration
- OUTPUT_UART_TX_CHANGE_DETECT_EN:
  - Defined: a 32-bit register holds the last sampled data_in, which resets to 0. The effective write strobe is word_en OR (data_in ≠ that register). The register updates every cycle. This lets the block attach to the CPU output_out alone, with no strobe available. Repeated identical values are not re-sent.
  - Undefined: the register and comparator are not instantiated. Only word_en writes.

## Test plan
- CLKS_PER_BIT=4, write 0x12345678 once:
  - tx falls one edge after the write;
  - decoded bytes are 0x12, 0x34, 0x56, 0x78, each with start 0 and stop 1;
  - total 160 cycles;
  - busy falls on the edge after the last stop bit.
- FIFO_DEPTH=4, word_en high for 6 consecutive cycles with values 1..6:
  - fifo_count after each edge: 1, 1, 2, 3, 4, 4;
  - value 6 is dropped and overflow=1;
  - tx emits words 1, 2, 3, 4, 5 in order.
- FIFO full while the FSM is in STOP of the last byte: write 0xAA on the pop edge → accepted, fifo_count stays 4, overflow stays 0.
- Assert clr during DATA of byte 2:
  - tx=1 immediately, fifo_count=0, busy=0;
  - after release, tx stays 1 for 200 cycles;
  - a new write of 0xDEADBEEF transmits correctly.
- Change-detect macro defined, word_en=0:
  - data_in steps 0 → 0x000000A5 and holds → exactly one word (0x00, 0x00, 0x00, 0xA5) is sent;
  - holding data_in for 500 cycles sends nothing more.
- Same stimulus with the macro undefined: tx stays 1 and busy stays 0.
